// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } hcu_state_t;

   // True when a non-x0 destination matches either decode source register
   function automatic logic reg_hit(
      input logic [REG_IDX_W-1:0] rd,
      input logic [REG_IDX_W-1:0] rs1,
      input logic [REG_IDX_W-1:0] rs2
   );
      return (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous reset; stops at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // Count enabled cycles, holding at the maximum value instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: memory-wait stalls with timeout, branch flushes
// and load-use interlocks, plus a saturating stall-cycle counter.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] rs1_decode,
   input  logic [REG_IDX_W-1:0] rs2_decode,
   input  logic [REG_IDX_W-1:0] rd_execute,
   input  logic                 mem_read_execute,
   input  logic                 mem_access_memory,
   input  logic                 mem_ready,
   input  logic                 branch_taken_execute,
   output logic                 stall_fetch,
   output logic                 stall_decode,
   output logic                 stall_execute,
   output logic                 stall_memory,
   output logic                 flush_decode,
   output logic                 flush_execute,
   output logic                 mem_timeout,
   output logic [CNT_W-1:0]     stall_cycles
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

   hcu_state_t state;
   hcu_state_t state_next;
   logic [7:0] wait_cnt;
   logic [7:0] wait_next;
   logic       timeout_set;
   logic       mem_stall_raw;
   logic       mem_stall;
   logic       flush;
   logic       load_use;
   logic       any_stall;

   // Memory-wait FSM: decides the stall for this cycle and the next wait state
   always_comb begin
      state_next    = state;
      wait_next     = wait_cnt;
      timeout_set   = 1'b0;
      mem_stall_raw = 1'b0;
      case (state)
         IDLE: begin
            if (mem_access_memory && !mem_ready) begin
               mem_stall_raw = 1'b1;
               state_next    = MEM_WAIT;
               wait_next     = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_next = IDLE;
               wait_next  = 8'd0;
            end else if (wait_cnt < TIMEOUT_LIMIT) begin
               mem_stall_raw = 1'b1;
               wait_next     = wait_cnt + 8'd1;
            end else begin
               timeout_set = 1'b1;
               state_next  = IDLE;
               wait_next   = 8'd0;
            end
         end
         default: begin
            state_next = IDLE;
            wait_next  = 8'd0;
         end
      endcase
   end

   // Output priority: memory wait, then branch flush, then load-use; reset silences all
   always_comb begin
      mem_stall = !rst && mem_stall_raw;
      flush     = !rst && !mem_stall && branch_taken_execute;
      load_use  = !rst && !mem_stall && !branch_taken_execute && mem_read_execute
                  && reg_hit(rd_execute, rs1_decode, rs2_decode);

      stall_fetch   = mem_stall || load_use;
      stall_decode  = mem_stall || load_use;
      stall_execute = mem_stall;
      stall_memory  = mem_stall;
      flush_decode  = flush;
      flush_execute = flush || load_use;
      any_stall     = mem_stall || load_use;
   end

   // State, wait counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= 8'd0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         if (timeout_set) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (any_stall),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit using an expected-value queue.
module tb_hazard_control_unit;

   localparam int unsigned MEM_TIMEOUT = 4;
   localparam int unsigned CNT_W       = 4;

   // Expected output flags: {stall_fetch, stall_decode, stall_execute, stall_memory, flush_decode, flush_execute}
   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] MEM  = 6'b111100;
   localparam logic [5:0] LU   = 6'b110001;
   localparam logic [5:0] FL   = 6'b000011;

   typedef struct {
      string            tag;
      logic [5:0]       flags;
      logic [CNT_W-1:0] cnt;
      logic             tmo;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [4:0]       rs1_decode;
   logic [4:0]       rs2_decode;
   logic [4:0]       rd_execute;
   logic             mem_read_execute;
   logic             mem_access_memory;
   logic             mem_ready;
   logic             branch_taken_execute;
   logic             stall_fetch;
   logic             stall_decode;
   logic             stall_execute;
   logic             stall_memory;
   logic             flush_decode;
   logic             flush_execute;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;

   exp_t             sb[$];
   int               vectors = 0;
   int               miscompares = 0;
   logic [CNT_W-1:0] model_cnt = '0;
   logic             model_tmo = 1'b0;

   hazard_control_unit #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .rs1_decode           (rs1_decode),
      .rs2_decode           (rs2_decode),
      .rd_execute           (rd_execute),
      .mem_read_execute     (mem_read_execute),
      .mem_access_memory    (mem_access_memory),
      .mem_ready            (mem_ready),
      .branch_taken_execute (branch_taken_execute),
      .stall_fetch          (stall_fetch),
      .stall_decode         (stall_decode),
      .stall_execute        (stall_execute),
      .stall_memory         (stall_memory),
      .flush_decode         (flush_decode),
      .flush_execute        (flush_execute),
      .mem_timeout          (mem_timeout),
      .stall_cycles         (stall_cycles)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pop the oldest expectation and compare it against the live outputs
   task automatic checkOutput();
      exp_t       e;
      logic [5:0] act;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e   = sb.pop_front();
      act = {stall_fetch, stall_decode, stall_execute, stall_memory, flush_decode, flush_execute};
      vectors++;
      assert (act === e.flags) else begin
         miscompares++;
         $error("[TB] FAIL %s.flags observed=%b expected=%b", e.tag, act, e.flags);
      end
      vectors++;
      assert (stall_cycles === e.cnt) else begin
         miscompares++;
         $error("[TB] FAIL %s.stall_cycles observed=%0d expected=%0d", e.tag, stall_cycles, e.cnt);
      end
      vectors++;
      assert (mem_timeout === e.tmo) else begin
         miscompares++;
         $error("[TB] FAIL %s.mem_timeout observed=%b expected=%b", e.tag, mem_timeout, e.tmo);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, check, then advance the model
   task automatic applyStimulus(
      input string      tag,
      input logic       r,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic [4:0] rd,
      input logic       mr,
      input logic       ma,
      input logic       rdy,
      input logic       br,
      input logic [5:0] flags
   );
      exp_t e;
      @(negedge clk);
      rst                  = r;
      rs1_decode           = rs1;
      rs2_decode           = rs2;
      rd_execute           = rd;
      mem_read_execute     = mr;
      mem_access_memory    = ma;
      mem_ready            = rdy;
      branch_taken_execute = br;
      e.tag   = tag;
      e.flags = flags;
      e.cnt   = model_cnt;
      e.tmo   = model_tmo;
      sb.push_back(e);
      #1;
      checkOutput();
      if (r) begin
         model_cnt = '0;
         model_tmo = 1'b0;
      end else if ((flags[5:2] != 4'b0000) && (model_cnt != {CNT_W{1'b1}})) begin
         model_cnt = model_cnt + 1'b1;
      end
   endtask

   initial begin
      rst                  = 1'b1;
      rs1_decode           = 5'd1;
      rs2_decode           = 5'd5;
      rd_execute           = 5'd5;
      mem_read_execute     = 1'b1;
      mem_access_memory    = 1'b1;
      mem_ready            = 1'b0;
      branch_taken_execute = 1'b1;
      @(posedge clk);

      // Reset holds every output low even with all hazards present
      applyStimulus("reset_quiet", 1, 5'd1, 5'd5, 5'd5, 1, 1, 0, 1, NONE);

      // Load-use on rs2 and rs1, non-matching load, x0 load, non-load match
      applyStimulus("lu_rs2",      0, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, LU);
      applyStimulus("lu_after",    0, 5'd1, 5'd2, 5'd5, 0, 0, 0, 0, NONE);
      applyStimulus("lu_rs1",      0, 5'd5, 5'd9, 5'd5, 1, 0, 0, 0, LU);
      applyStimulus("lu_nomatch",  0, 5'd6, 5'd7, 5'd5, 1, 0, 0, 0, NONE);
      applyStimulus("x0_load",     0, 5'd0, 5'd3, 5'd0, 1, 0, 0, 0, NONE);
      applyStimulus("not_load",    0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, NONE);

      // Branch flush alone, and branch suppressing a load-use match
      applyStimulus("branch",      0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, FL);
      applyStimulus("branch_lu",   0, 5'd5, 5'd2, 5'd5, 1, 0, 0, 1, FL);

      // Three-cycle memory wait then release on ready
      applyStimulus("mw_1",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("mw_2",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("mw_3",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("mw_ready",    0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, NONE);
      applyStimulus("mw_idle",     0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, NONE);

      // Branch and load-use held through a two-cycle wait; flush only at release
      applyStimulus("wb_1",        0, 5'd1, 5'd5, 5'd5, 1, 1, 0, 1, MEM);
      applyStimulus("wb_2",        0, 5'd1, 5'd5, 5'd5, 1, 1, 0, 1, MEM);
      applyStimulus("wb_ready",    0, 5'd1, 5'd5, 5'd5, 1, 1, 1, 1, FL);
      applyStimulus("wb_idle",     0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, NONE);

      // Timeout: four stall cycles, forced release on the fifth, sticky flag
      applyStimulus("to_1",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("to_2",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("to_3",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("to_4",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("to_release",  0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, NONE);
      model_tmo = 1'b1;
      applyStimulus("to_sticky1",  0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, NONE);
      applyStimulus("to_sticky2",  0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, NONE);

      // Reset during the second wait cycle abandons the wait
      applyStimulus("rw_1",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("rw_2",        0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, MEM);
      applyStimulus("rw_rst",      1, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, NONE);
      applyStimulus("rw_idle",     0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, NONE);
      applyStimulus("rw_lu",       0, 5'd4, 5'd2, 5'd4, 1, 0, 0, 0, LU);

      // Hold a load-use long enough to saturate the stall counter
      for (int i = 0; i < 17; i++) begin
         applyStimulus("sat_hold", 0, 5'd4, 5'd2, 5'd4, 1, 0, 0, 0, LU);
      end
      applyStimulus("sat_end",     0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, NONE);

      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
